spart_rx_fifo: RTL and testbench

//  Parametrised SPART receiver. Deserialises async serial frames on rxd into a show-ahead receive FIFO.

---
 rtl/spart_rx_fifo_if.sv | 26 ++
 rtl/spart_rx_fifo.sv | 212 +++++++++++++++++++++
 tb/tb_spart_rx_fifo.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spart_rx_fifo_if.sv
// Bus-side signal bundle for the SPART receiver: baud tick, serial line, FIFO pop/clear controls and status.
// The slave modport is the receiver's view; the master modport is the SPART bus/board side.
interface spart_rx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 enable;
  logic                 rxd;
  logic                 rd;
  logic                 clr_err;
  logic                 parity_odd;
  logic [DATA_BITS-1:0] data;
  logic                 rda;
  logic                 frame_err;
  logic                 overrun;
  logic                 par_err;

  modport master (
    output enable, rxd, rd, clr_err, parity_odd,
    input  data, rda, frame_err, overrun, par_err
  );

  modport slave (
    input  enable, rxd, rd, clr_err, parity_odd,
    output data, rda, frame_err, overrun, par_err
  );
endinterface

// File: rtl/spart_rx_fifo.sv
// SPART receiver: oversampled serial deserialiser feeding a show-ahead receive FIFO with sticky error flags.
// Define SPART_RX_PARITY_EN to add a parity bit to the frame and enable par_err / parity_odd.
module spart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  spart_rx_fifo_if.slave  bus
);

  localparam int HALF   = OVERSAMPLE / 2;
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(HALF - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

`ifdef SPART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t               state;
  logic                 rx_meta;
  logic                 rxs;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 push_req;
  logic                 frame_err_q;
  logic                 overrun_q;
`ifdef SPART_RX_PARITY_EN
  logic                 par_bad;
  logic                 par_err_q;
`else
  logic                 unused_parity_odd;
`endif

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 empty;
  logic                 full;
  logic                 rd_en;
  logic                 wr_en;
  logic                 overrun_set;

  // rxd is asynchronous to clk; idle-high reset keeps the FSM from seeing a phantom start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.rxd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      push_req    <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SPART_RX_PARITY_EN
      par_bad     <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      push_req <= 1'b0;
      if (bus.clr_err) begin
        frame_err_q <= 1'b0;
`ifdef SPART_RX_PARITY_EN
        par_err_q   <= 1'b0;
`endif
      end
      // Flag sets below are later assignments, so they override a same-cycle clear
      if (bus.enable) begin
        case (state)
          IDLE: begin
            if (!rxs) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rxs ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              shift    <= {rxs, shift[DATA_BITS-1:1]};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
`ifdef SPART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`ifdef SPART_RX_PARITY_EN
          PARITY: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              par_bad  <= rxs ^ (^shift) ^ bus.parity_odd;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              if (!rxs) begin
                frame_err_q <= 1'b1;
                state       <= BREAK;
`ifdef SPART_RX_PARITY_EN
              end else if (par_bad) begin
                par_err_q <= 1'b1;
                state     <= IDLE;
`endif
              end else begin
                push_req <= 1'b1;
                state    <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          BREAK: begin
            if (rxs) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign empty       = (count == '0);
  assign full        = (count == DEPTH_CNT);
  assign rd_en       = bus.rd & ~empty;
  // When full, a simultaneous pop frees the slot the new word lands in
  assign wr_en       = push_req & (~full | rd_en);
  assign overrun_set = push_req & full & ~rd_en;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (overrun_set) begin
        overrun_q <= 1'b1;
      end else if (bus.clr_err) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.data      = empty ? '0 : mem[rd_ptr];
  assign bus.rda       = ~empty;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
`ifdef SPART_RX_PARITY_EN
  assign bus.par_err   = par_err_q;
`else
  assign bus.par_err   = 1'b0;
  assign unused_parity_odd = bus.parity_odd;
`endif

endmodule

// File: tb/tb_spart_rx_fifo.sv
// Directed bench for spart_rx_fifo (DATA_BITS=8, OVERSAMPLE=16, FIFO_DEPTH=4); enable ticks every other clk.
// Frames include a parity bit only when SPART_RX_PARITY_EN is defined, matching the DUT build.
module tb_spart_rx_fifo;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int FIFO_DEPTH = 4;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  int   wait_cycles;

  spart_rx_fifo_if #(.DATA_BITS(DATA_BITS)) bus ();

  spart_rx_fifo #(
    .DATA_BITS  (DATA_BITS),
    .OVERSAMPLE (OVERSAMPLE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick: one-cycle pulse on every second clk, changed away from the active edge
  initial begin
    bus.enable = 1'b0;
    forever begin
      @(negedge clk);
      bus.enable = ~bus.enable;
    end
  end

  task automatic check_output(input string tag, input logic [8:0] observed, input logic [8:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!bus.enable) @(posedge clk);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    bus.rxd = b;
    wait_ticks(OVERSAMPLE);
  endtask

  function automatic logic good_parity(input logic [7:0] d);
    return (^d) ^ bus.parity_odd;
  endfunction

  task automatic apply_stimulus(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) begin
      drive_bit(d[i]);
    end
`ifdef SPART_RX_PARITY_EN
    drive_bit(par_bit);
`else
    if (par_bit) begin
      @(negedge clk);
    end
`endif
    drive_bit(stop_bit);
    @(negedge clk);
  endtask

  task automatic pop_word();
    @(negedge clk);
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  task automatic clear_errors();
    @(negedge clk);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    wait_cycles    = 0;
    rst_n          = 1'b0;
    bus.rxd        = 1'b1;
    bus.rd         = 1'b0;
    bus.clr_err    = 1'b0;
    bus.parity_odd = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_output("reset_data", 9'(bus.data), 9'h000);
    check_output("reset_rda", 9'(bus.rda), 9'h0);
    check_output("reset_frame_err", 9'(bus.frame_err), 9'h0);
    check_output("reset_overrun", 9'(bus.overrun), 9'h0);
    check_output("reset_par_err", 9'(bus.par_err), 9'h0);
    rst_n = 1'b1;
    wait_ticks(2 * OVERSAMPLE);

    // 1: single good frame, then pop
    apply_stimulus(8'h55, 1'b1, good_parity(8'h55));
    check_output("t1_rda", 9'(bus.rda), 9'h1);
    check_output("t1_data", 9'(bus.data), 9'h055);
    check_output("t1_frame_err", 9'(bus.frame_err), 9'h0);
    check_output("t1_overrun", 9'(bus.overrun), 9'h0);
    check_output("t1_par_err", 9'(bus.par_err), 9'h0);
    pop_word();
    check_output("t1_rda_after_pop", 9'(bus.rda), 9'h0);

    // 2: false start glitch of 4 ticks
    @(negedge clk);
    bus.rxd = 1'b0;
    wait_ticks(4);
    @(negedge clk);
    bus.rxd = 1'b1;
    wait_ticks(2 * OVERSAMPLE);
    @(negedge clk);
    check_output("t2_rda", 9'(bus.rda), 9'h0);
    check_output("t2_frame_err", 9'(bus.frame_err), 9'h0);

    // 3: bad stop bit then break; cleared flag must not re-arm while the line stays low
    apply_stimulus(8'hA3, 1'b0, good_parity(8'hA3));
    check_output("t3_frame_err_set", 9'(bus.frame_err), 9'h1);
    check_output("t3_rda", 9'(bus.rda), 9'h0);
    clear_errors();
    check_output("t3_frame_err_clr", 9'(bus.frame_err), 9'h0);
    wait_ticks(40 * OVERSAMPLE);
    @(negedge clk);
    check_output("t3_frame_err_once", 9'(bus.frame_err), 9'h0);
    check_output("t3_rda_break", 9'(bus.rda), 9'h0);
    bus.rxd = 1'b1;
    wait_ticks(2 * OVERSAMPLE);
    apply_stimulus(8'h12, 1'b1, good_parity(8'h12));
    check_output("t3_rda_12", 9'(bus.rda), 9'h1);
    check_output("t3_data_12", 9'(bus.data), 9'h012);
    check_output("t3_frame_err_12", 9'(bus.frame_err), 9'h0);
    pop_word();

    // 4a: five frames into a 4-deep FIFO without popping
    for (int i = 1; i <= 5; i++) begin
      apply_stimulus(8'(i), 1'b1, good_parity(8'(i)));
      if (i == 4) begin
        check_output("t4_overrun_at_4", 9'(bus.overrun), 9'h0);
      end
    end
    check_output("t4_overrun", 9'(bus.overrun), 9'h1);
    for (int i = 1; i <= 4; i++) begin
      check_output("t4_pop_rda", 9'(bus.rda), 9'h1);
      check_output("t4_pop_data", 9'(bus.data), 9'(i));
      pop_word();
    end
    check_output("t4_empty", 9'(bus.rda), 9'h0);
    pop_word();
    check_output("t4_pop_empty", 9'(bus.rda), 9'h0);
    clear_errors();
    check_output("t4_overrun_clr", 9'(bus.overrun), 9'h0);

    // 4b: same fill, but pop exactly in the 5th push cycle
    for (int i = 1; i <= 4; i++) begin
      apply_stimulus(8'(i), 1'b1, good_parity(8'(i)));
    end
    fork
      apply_stimulus(8'h05, 1'b1, good_parity(8'h05));
      begin
        wait_cycles = 0;
        while (!dut.push_req && wait_cycles < 2000) begin
          @(negedge clk);
          wait_cycles++;
        end
        if (wait_cycles >= 2000) begin
          check_output("t4_push_wait_timeout", 9'h0, 9'h1);
        end else begin
          bus.rd = 1'b1;
          @(negedge clk);
          bus.rd = 1'b0;
        end
      end
    join
    check_output("t4b_overrun", 9'(bus.overrun), 9'h0);
    for (int i = 2; i <= 5; i++) begin
      check_output("t4b_pop_data", 9'(bus.data), 9'(i));
      pop_word();
    end
    check_output("t4b_empty", 9'(bus.rda), 9'h0);

    // 5: parity
`ifdef SPART_RX_PARITY_EN
    bus.parity_odd = 1'b0;
    apply_stimulus(8'h07, 1'b1, 1'b0);
    check_output("t5_par_err", 9'(bus.par_err), 9'h1);
    check_output("t5_rda_bad", 9'(bus.rda), 9'h0);
    clear_errors();
    check_output("t5_par_err_clr", 9'(bus.par_err), 9'h0);
    apply_stimulus(8'h07, 1'b1, 1'b1);
    check_output("t5_rda_good", 9'(bus.rda), 9'h1);
    check_output("t5_data_good", 9'(bus.data), 9'h007);
    check_output("t5_par_err_good", 9'(bus.par_err), 9'h0);
    pop_word();
`else
    bus.parity_odd = 1'b1;
    apply_stimulus(8'h07, 1'b1, 1'b0);
    check_output("t5_par_err_tied", 9'(bus.par_err), 9'h0);
    check_output("t5_data_noparity", 9'(bus.data), 9'h007);
    pop_word();
    bus.parity_odd = 1'b0;
`endif

    // 6: reset in the middle of a frame, with a stored word and a raised flag
    apply_stimulus(8'h99, 1'b1, good_parity(8'h99));
    apply_stimulus(8'h5A, 1'b0, good_parity(8'h5A));
    @(negedge clk);
    bus.rxd = 1'b1;
    wait_ticks(2 * OVERSAMPLE);
    check_output("t6_pre_rda", 9'(bus.rda), 9'h1);
    check_output("t6_pre_frame_err", 9'(bus.frame_err), 9'h1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) begin
      drive_bit(((8'hC3 >> i) & 8'h01) != 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("t6_rst_data", 9'(bus.data), 9'h000);
    check_output("t6_rst_rda", 9'(bus.rda), 9'h0);
    check_output("t6_rst_frame_err", 9'(bus.frame_err), 9'h0);
    check_output("t6_rst_overrun", 9'(bus.overrun), 9'h0);
    check_output("t6_rst_par_err", 9'(bus.par_err), 9'h0);
    bus.rxd = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(2 * OVERSAMPLE);
    apply_stimulus(8'h3C, 1'b1, good_parity(8'h3C));
    check_output("t6_rda_3c", 9'(bus.rda), 9'h1);
    check_output("t6_data_3c", 9'(bus.data), 9'h03C);
    pop_word();
    check_output("t6_empty", 9'(bus.rda), 9'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
